// File: rtl/measurement_loader.sv
// measurement_loader: double-buffered loader for three IEEE-754 words {y1,y2,y3}.
// Words fill a shadow buffer; the full shadow is published to buff_y once the
// post-publish hold window has expired, so buff_y stays stable for at least
// HOLD_CYCLES cycles after every publish.
// Optional build macro: MEASUREMENT_NAN_CHECK_EN drops frames that contain a
// NaN/Inf word (exponent 8'hFF) and pulses frame_err instead of publishing.
module measurement_loader #(
    parameter int unsigned HOLD_CYCLES = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [95:0] buff_y,
    output logic        y_valid,
    output logic [1:0]  word_cnt,
    output logic [15:0] frames_out,
    output logic        frame_err
);

    localparam logic [3:0] L_HOLD = 4'(HOLD_CYCLES);

    logic [95:0] r_shadow;
    logic [95:0] r_buff_y;
    logic        r_y_valid;
    logic [1:0]  r_word_cnt;
    logic [3:0]  r_hold_cnt;
    logic [15:0] r_frames_out;
    logic        r_frame_err;

    logic w_accept;
    logic w_full;
    logic w_publish_slot;
    logic w_frame_bad;

    // Shadow is full exactly when three words are held; only then is the input stalled.
    assign w_full         = (r_word_cnt == 2'd3);
    assign s_ready        = rst_n & ~w_full;
    assign w_accept       = s_valid & s_ready;
    assign w_publish_slot = w_full & (r_hold_cnt == 4'd0);

`ifdef MEASUREMENT_NAN_CHECK_EN
    // Exponent all-ones marks NaN or Inf in any of the three words.
    assign w_frame_bad = (r_shadow[94:87] == 8'hFF) |
                         (r_shadow[62:55] == 8'hFF) |
                         (r_shadow[30:23] == 8'hFF);
`else
    assign w_frame_bad = 1'b0;
`endif

    // Fill the shadow, run the hold timer and publish or drop full frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow     <= '0;
            r_buff_y     <= '0;
            r_y_valid    <= 1'b0;
            r_word_cnt   <= 2'd0;
            r_hold_cnt   <= 4'd0;
            r_frames_out <= 16'd0;
            r_frame_err  <= 1'b0;
        end else begin
            r_y_valid   <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_publish_slot) begin
                // Publish and drop both free the shadow for the next frame.
                r_word_cnt <= 2'd0;
                if (w_frame_bad) begin
                    // Dropped frame: buff_y, frames_out and hold timer untouched.
                    r_frame_err <= 1'b1;
                end else begin
                    r_buff_y     <= r_shadow;
                    r_y_valid    <= 1'b1;
                    r_frames_out <= r_frames_out + 16'd1;
                    r_hold_cnt   <= L_HOLD;
                end
            end else begin
                if (r_hold_cnt != 4'd0) begin
                    r_hold_cnt <= r_hold_cnt - 4'd1;
                end
                if (w_accept) begin
                    case (r_word_cnt)
                        2'd0:    r_shadow[95:64] <= s_data;
                        2'd1:    r_shadow[63:32] <= s_data;
                        default: r_shadow[31:0]  <= s_data;
                    endcase
                    r_word_cnt <= r_word_cnt + 2'd1;
                end
            end
        end
    end

    assign buff_y     = r_buff_y;
    assign y_valid    = r_y_valid;
    assign word_cnt   = r_word_cnt;
    assign frames_out = r_frames_out;
    assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_measurement_loader.sv
// Self-checking bench for measurement_loader (HOLD_CYCLES = 5).
// Table-driven cycle vectors for basic load and hold backpressure, then
// hand-written sequences for gaps, reset mid-frame, NaN handling and wrap.
module tb_measurement_loader;

    logic        clk;
    logic        rst_n;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [95:0] buff_y;
    logic        y_valid;
    logic [1:0]  word_cnt;
    logic [15:0] frames_out;
    logic        frame_err;

    int checks   = 0;
    int failures = 0;

    measurement_loader #(
        .HOLD_CYCLES(5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .buff_y     (buff_y),
        .y_valid    (y_valid),
        .word_cnt   (word_cnt),
        .frames_out (frames_out),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] data;
        logic        ready;
        logic [1:0]  wc;
        logic        yv;
        logic [15:0] fo;
        logic [95:0] by;
    } vec_t;

    vec_t vecs[12];

    // Publish monitor: captures every published vector and checks stability.
    logic [95:0] pub_q[$];
    int          pub_cnt = 0;
    logic [95:0] prev_by = '0;
    logic        prev_yv = 1'b0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_by = '0;
            prev_yv = 1'b0;
        end else begin
            checks++;
            if (!y_valid && buff_y !== prev_by) begin
                failures++;
                $display("FAIL buff_y_stable: got %h expected %h", buff_y, prev_by);
            end
            checks++;
            if (y_valid && prev_yv) begin
                failures++;
                $display("FAIL y_valid_pulse: got 2-cycle pulse expected 1-cycle");
            end
            if (y_valid) begin
                pub_q.push_back(buff_y);
                pub_cnt++;
            end
            prev_by = buff_y;
            prev_yv = y_valid;
        end
    end

    // Offer one word from a negedge; returns at the negedge after it is taken.
    task automatic send_word(input logic [31:0] d);
        int   n   = 0;
        logic acc = 1'b0;
        s_data  = d;
        s_valid = 1'b1;
        while (!acc && n < 50) begin
            acc = s_ready;
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL send_word: got no accept expected accept of %h", d);
        end
    endtask

    task automatic wait_pub(input string name);
        int   n   = 0;
        logic got = 1'b0;
        while (!got && n < 30) begin
            @(posedge clk);
            @(negedge clk);
            got = y_valid;
            n++;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s: got no y_valid expected publish", name);
        end
    endtask

    initial begin
        logic [95:0] gf[3];
        logic [95:0] rf;
        logic [95:0] nf;
        logic [95:0] w1;
        logic [95:0] w2;
        int          base;
        int          n;

        vecs[0]  = '{1'b0, 32'h0,        1'b1, 2'd0, 1'b0, 16'd0, 96'h0};
        vecs[1]  = '{1'b1, 32'hc1500000, 1'b1, 2'd1, 1'b0, 16'd0, 96'h0};
        vecs[2]  = '{1'b1, 32'h40000000, 1'b1, 2'd2, 1'b0, 16'd0, 96'h0};
        vecs[3]  = '{1'b1, 32'h41260000, 1'b0, 2'd3, 1'b0, 16'd0, 96'h0};
        vecs[4]  = '{1'b1, 32'h3f800000, 1'b1, 2'd0, 1'b1, 16'd1,
                     96'hc15000004000000041260000};
        vecs[5]  = '{1'b1, 32'h3f800000, 1'b1, 2'd1, 1'b0, 16'd1,
                     96'hc15000004000000041260000};
        vecs[6]  = '{1'b1, 32'h40400000, 1'b1, 2'd2, 1'b0, 16'd1,
                     96'hc15000004000000041260000};
        vecs[7]  = '{1'b1, 32'h40a00000, 1'b0, 2'd3, 1'b0, 16'd1,
                     96'hc15000004000000041260000};
        vecs[8]  = '{1'b1, 32'h12345678, 1'b0, 2'd3, 1'b0, 16'd1,
                     96'hc15000004000000041260000};
        vecs[9]  = '{1'b1, 32'h12345678, 1'b0, 2'd3, 1'b0, 16'd1,
                     96'hc15000004000000041260000};
        vecs[10] = '{1'b1, 32'h12345678, 1'b1, 2'd0, 1'b1, 16'd2,
                     96'h3f8000004040000040a00000};
        vecs[11] = '{1'b0, 32'h0,        1'b1, 2'd0, 1'b0, 16'd2,
                     96'h3f8000004040000040a00000};

        gf[0] = 96'h3f800001_3f800002_3f800003;
        gf[1] = 96'h3f800004_3f800005_3f800006;
        gf[2] = 96'h3f800007_3f800008_3f800009;
        rf    = 96'hbf800000_40e00000_41000000;
        nf    = 96'h3f800000_7fc00000_40000000;
        w1    = 96'h41100000_41200000_41300000;
        w2    = 96'h41400000_41500000_41600000;

        // Reset state
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        repeat (3) @(negedge clk);
        chk("rst_buff_y", buff_y, 96'h0);
        chk("rst_y_valid", {95'h0, y_valid}, 96'h0);
        chk("rst_word_cnt", {94'h0, word_cnt}, 96'h0);
        chk("rst_frames_out", {80'h0, frames_out}, 96'h0);
        chk("rst_frame_err", {95'h0, frame_err}, 96'h0);
        chk("rst_s_ready", {95'h0, s_ready}, 96'h0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Basic load and hold backpressure, cycle by cycle
        for (int i = 0; i < 12; i++) begin
            s_valid = vecs[i].valid;
            s_data  = vecs[i].data;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d_s_ready", i), {95'h0, s_ready}, {95'h0, vecs[i].ready});
            chk($sformatf("vec%0d_word_cnt", i), {94'h0, word_cnt}, {94'h0, vecs[i].wc});
            chk($sformatf("vec%0d_y_valid", i), {95'h0, y_valid}, {95'h0, vecs[i].yv});
            chk($sformatf("vec%0d_frames_out", i), {80'h0, frames_out}, {80'h0, vecs[i].fo});
            chk($sformatf("vec%0d_buff_y", i), buff_y, vecs[i].by);
            chk($sformatf("vec%0d_frame_err", i), {95'h0, frame_err}, 96'h0);
        end

        // Gaps: random idle cycles between words, three frames
        pub_q.delete();
        base = pub_cnt;
        for (int f = 0; f < 3; f++) begin
            for (int w = 0; w < 3; w++) begin
                s_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
                send_word(gf[f][95 - 32 * w -: 32]);
            end
        end
        s_valid = 1'b0;
        n = 0;
        while (pub_cnt < base + 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("gap_pub_count", 96'(pub_cnt - base), 96'd3);
        for (int f = 0; f < 3; f++) begin
            if (pub_q.size() > f) chk($sformatf("gap_frame%0d", f), pub_q[f], gf[f]);
        end
        chk("gap_frames_out", {80'h0, frames_out}, 96'd5);

        // Reset mid-frame: partial shadow discarded
        send_word(32'h11111111);
        send_word(32'h22222222);
        s_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_buff_y", buff_y, 96'h0);
        chk("midrst_y_valid", {95'h0, y_valid}, 96'h0);
        chk("midrst_word_cnt", {94'h0, word_cnt}, 96'h0);
        chk("midrst_frames_out", {80'h0, frames_out}, 96'h0);
        chk("midrst_s_ready", {95'h0, s_ready}, 96'h0);
        @(posedge clk);
        @(negedge clk);
        chk("midrst_hold_word_cnt", {94'h0, word_cnt}, 96'h0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        send_word(rf[95:64]);
        send_word(rf[63:32]);
        send_word(rf[31:0]);
        s_valid = 1'b0;
        chk("lat_word_cnt_full", {94'h0, word_cnt}, 96'd3);
        chk("lat_y_valid_early", {95'h0, y_valid}, 96'h0);
        chk("lat_s_ready_full", {95'h0, s_ready}, 96'h0);
        @(posedge clk);
        @(negedge clk);
        chk("lat_y_valid", {95'h0, y_valid}, 96'h1);
        chk("lat_buff_y", buff_y, rf);
        chk("lat_frames_out", {80'h0, frames_out}, 96'd1);
        chk("lat_word_cnt", {94'h0, word_cnt}, 96'h0);

        // NaN in y2
        send_word(nf[95:64]);
        send_word(nf[63:32]);
        send_word(nf[31:0]);
        s_valid = 1'b0;
`ifdef MEASUREMENT_NAN_CHECK_EN
        n = 0;
        while (!frame_err && !y_valid && n < 30) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk("nan_frame_err", {95'h0, frame_err}, 96'h1);
        chk("nan_y_valid", {95'h0, y_valid}, 96'h0);
        chk("nan_buff_y", buff_y, rf);
        chk("nan_frames_out", {80'h0, frames_out}, 96'd1);
        chk("nan_word_cnt", {94'h0, word_cnt}, 96'h0);
        @(posedge clk);
        @(negedge clk);
        chk("nan_frame_err_pulse", {95'h0, frame_err}, 96'h0);
`else
        wait_pub("nan_publish");
        chk("nan_buff_y", buff_y, nf);
        chk("nan_frames_out", {80'h0, frames_out}, 96'd2);
        chk("nan_frame_err", {95'h0, frame_err}, 96'h0);
`endif

        // Wrap of frames_out
        repeat (8) @(negedge clk);
        force dut.r_frames_out = 16'hFFFE;
        @(posedge clk);
        @(negedge clk);
        release dut.r_frames_out;
        send_word(w1[95:64]);
        send_word(w1[63:32]);
        send_word(w1[31:0]);
        s_valid = 1'b0;
        wait_pub("wrap_pub1");
        chk("wrap_ffff", {80'h0, frames_out}, 96'h0FFFF);
        send_word(w2[95:64]);
        send_word(w2[63:32]);
        send_word(w2[31:0]);
        s_valid = 1'b0;
        wait_pub("wrap_pub2");
        chk("wrap_zero", {80'h0, frames_out}, 96'h0);
        chk("wrap_buff_y", buff_y, w2);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/measurement_loader.md
MEASUREMENT_LOADER -- requirements
Module: measurement_loader

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 5, range 0..15: minimum clk cycles buff_y stays stable after each publish before the next publish.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port s_data, input, 32, IEEE-754 single-precision measurement word.
REQ-005 SHALL have port s_valid, input, 1, s_data valid.
REQ-006 SHALL have port s_ready, output, 1, loader can accept a word.
REQ-007 SHALL have port buff_y, output, 96, published measurement vector {y1,y2,y3} for the contribution stage.
REQ-008 SHALL have port y_valid, output, 1, one-cycle pulse marking a new buff_y.
REQ-009 SHALL have port word_cnt, output, 2, words held in the shadow buffer (0..3).
REQ-010 SHALL have port frames_out, output, 16, count of published frames.
REQ-011 SHALL have port frame_err, output, 1, one-cycle pulse marking a dropped frame.

Function
REQ-012 SHALL accept a word on a rising edge where s_valid=1 and s_ready=1; no other edge changes the shadow buffer except publish/drop clear.
REQ-013 SHALL steer accepted words in order: 1st to shadow[95:64] (y1), 2nd to shadow[63:32] (y2), 3rd to shadow[31:0] (y3).
REQ-014 SHALL drive s_ready = rst_n AND (word_cnt<3), from registers only, with no combinational path from s_valid.
REQ-015 SHALL keep buff_y unchanged while the shadow fills; the shadow and buff_y are independent (double buffer).
REQ-016 SHALL publish on the first edge where word_cnt=3 and hold_cnt=0: buff_y<=shadow, y_valid=1 for exactly that following cycle, word_cnt<=0, hold_cnt<=HOLD_CYCLES, frames_out<=frames_out+1.
REQ-017 SHALL give latency: 3rd word accepted at edge N with hold_cnt=0, then buff_y and y_valid are visible after edge N+1.
REQ-018 SHALL decrement hold_cnt by 1 per cycle while it is nonzero, so consecutive publishes are at least HOLD_CYCLES+1 edges apart; with HOLD_CYCLES=0, publishes may be every 4th edge.
REQ-019 SHALL hold the full shadow with s_ready=0 while word_cnt=3 and hold_cnt>0, losing no data.
REQ-020 SHALL wrap frames_out from 0xFFFF to 0x0000 silently.
REQ-021 SHALL ignore s_data and s_valid when s_ready=0.

Reset
REQ-022 SHALL, while rst_n=0, immediately force buff_y=0, y_valid=0, word_cnt=0, hold_cnt=0, frames_out=0, frame_err=0, s_ready=0.
REQ-023 SHALL, on reset assertion mid-frame, discard the partial shadow, and the first word after release SHALL be treated as y1.
REQ-024 SHALL allow the first publish after reset without hold delay.

Configuration
REQ-025 SHALL, when macro MEASUREMENT_NAN_CHECK_EN is defined, drop a frame at its publish point if any word has exponent 8'hFF (NaN/Inf).
REQ-026 SHALL, on such a drop, leave buff_y and frames_out unchanged, keep y_valid=0, pulse frame_err for one cycle, clear word_cnt to 0, and leave hold_cnt unchanged.
REQ-027 SHALL, without MEASUREMENT_NAN_CHECK_EN, publish every frame and tie frame_err to 0.

Verification
REQ-028 SHALL cover basic load: after reset, send c1500000, 40000000, 41260000 back-to-back -> buff_y=c15000004000000041260000 one edge after the 3rd accept, y_valid one cycle, frames_out=1.
REQ-029 SHALL cover hold backpressure: HOLD_CYCLES=5, two frames streamed continuously -> s_ready low with word_cnt=3 until the hold expires, 2nd publish exactly 6 edges after the 1st, buff_y stable in between.
REQ-030 SHALL cover gaps: toggle s_valid randomly with 3 frames -> word order is preserved, 3 y_valid pulses, no duplicated or lost words.
REQ-031 SHALL cover reset mid-frame: 2 words accepted, then rst_n low 1 cycle -> all outputs zero; a following 3-word frame is published intact.
REQ-032 SHALL cover NaN drop with MEASUREMENT_NAN_CHECK_EN: frame with y2=7fc00000 -> frame_err pulse, buff_y unchanged, frames_out unchanged; without the macro the same frame is published.
REQ-033 SHALL cover wrap: preload frames_out near 0xFFFF via 2 frames -> frames_out reads 0x0000 after the wrapping publish.
